// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB bundle, ID read ports and write-back outputs of the register file
interface wb_regfile_if #(
  parameter int CNT_W = 32
);
  logic             Wr_Valid;
  logic             Wr_RegWr;
  logic             Wr_MemtoReg;
  logic             Wr_Link;
  logic [2:0]       Wr_LdType;
  logic [4:0]       Wr_Rw;
  logic [31:0]      Wr_dout;
  logic [31:0]      Wr_alu_result;
  logic [29:0]      Wr_PC;
  logic [4:0]       Ra;
  logic [4:0]       Rb;
  logic [31:0]      busA;
  logic [31:0]      busB;
  logic [31:0]      Wr_Data;
  logic             Wr_En;
  logic [CNT_W-1:0] Ret_Cnt;

  modport master (
    output Wr_Valid, Wr_RegWr, Wr_MemtoReg, Wr_Link, Wr_LdType, Wr_Rw,
           Wr_dout, Wr_alu_result, Wr_PC, Ra, Rb,
    input  busA, busB, Wr_Data, Wr_En, Ret_Cnt
  );

  modport slave (
    input  Wr_Valid, Wr_RegWr, Wr_MemtoReg, Wr_Link, Wr_LdType, Wr_Rw,
           Wr_dout, Wr_alu_result, Wr_PC, Ra, Rb,
    output busA, busB, Wr_Data, Wr_En, Ret_Cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back source select, 32x32 register file with write bypass, retire counter
module wb_regfile #(
  parameter bit BYPASS_EN = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  wb_regfile_if.slave bus
);

  logic [31:0]      regs_q [32];
  logic [CNT_W-1:0] ret_cnt_q;
  logic [CNT_W-1:0] ret_cnt_d;

  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      load_fmt;
  logic [29:0]      pc_next;
  logic [31:0]      link_addr;
  logic [31:0]      wb_data;
  logic             wr_en;

  always_comb begin
    ld_byte  = 8'h00;
    ld_half  = 16'h0000;
    load_fmt = bus.Wr_dout;
    case (bus.Wr_alu_result[1:0])
      2'd0:    ld_byte = bus.Wr_dout[7:0];
      2'd1:    ld_byte = bus.Wr_dout[15:8];
      2'd2:    ld_byte = bus.Wr_dout[23:16];
      default: ld_byte = bus.Wr_dout[31:24];
    endcase
    // Halfword bit 0 of the offset is ignored: misaligned LH/LHU reads the containing half.
    ld_half = bus.Wr_alu_result[1] ? bus.Wr_dout[31:16] : bus.Wr_dout[15:0];
    case (bus.Wr_LdType)
      3'd1:    load_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'd2:    load_fmt = {24'h000000, ld_byte};
      3'd3:    load_fmt = {{16{ld_half[15]}}, ld_half};
      3'd4:    load_fmt = {16'h0000, ld_half};
      default: load_fmt = bus.Wr_dout;
    endcase
  end

  assign pc_next   = bus.Wr_PC + 30'd1;
  assign link_addr = {pc_next, 2'b00};
  assign wb_data   = bus.Wr_Link     ? link_addr :
                     bus.Wr_MemtoReg ? load_fmt  : bus.Wr_alu_result;
  assign wr_en     = bus.Wr_Valid & bus.Wr_RegWr & (bus.Wr_Rw != 5'd0) & ~Reset;

  assign bus.busA    = (bus.Ra == 5'd0) ? 32'h0 :
                       (BYPASS_EN && wr_en && (bus.Ra == bus.Wr_Rw)) ? wb_data : regs_q[bus.Ra];
  assign bus.busB    = (bus.Rb == 5'd0) ? 32'h0 :
                       (BYPASS_EN && wr_en && (bus.Rb == bus.Wr_Rw)) ? wb_data : regs_q[bus.Rb];
  assign bus.Wr_Data = wb_data;
  assign bus.Wr_En   = wr_en;
  assign bus.Ret_Cnt = ret_cnt_q;

  assign ret_cnt_d = ret_cnt_q + {{(CNT_W-1){1'b0}}, bus.Wr_Valid};

  // wr_en already excludes register 0, so regs_q[0] stays at its reset value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
      ret_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[bus.Wr_Rw] <= wb_data;
      end
      ret_cnt_q <= ret_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile against an array-based reference model
module tb_wb_regfile;

  logic Clk = 1'b1;
  logic Reset;
  always #5 Clk = ~Clk;

  wb_regfile_if #(.CNT_W(32)) bus ();
  wb_regfile_if #(.CNT_W(4))  bus4 ();

  wb_regfile #(.BYPASS_EN(1'b1), .CNT_W(32)) dut  (.Clk(Clk), .Reset(Reset), .bus(bus));
  wb_regfile #(.BYPASS_EN(1'b1), .CNT_W(4))  dut4 (.Clk(Clk), .Reset(Reset), .bus(bus4));

  // The narrow-counter instance sees the same stimulus so counter wrap is observed quickly.
  assign bus4.Wr_Valid      = bus.Wr_Valid;
  assign bus4.Wr_RegWr      = bus.Wr_RegWr;
  assign bus4.Wr_MemtoReg   = bus.Wr_MemtoReg;
  assign bus4.Wr_Link       = bus.Wr_Link;
  assign bus4.Wr_LdType     = bus.Wr_LdType;
  assign bus4.Wr_Rw         = bus.Wr_Rw;
  assign bus4.Wr_dout       = bus.Wr_dout;
  assign bus4.Wr_alu_result = bus.Wr_alu_result;
  assign bus4.Wr_PC         = bus.Wr_PC;
  assign bus4.Ra            = bus.Ra;
  assign bus4.Rb            = bus.Rb;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] wd;
    logic        en;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_regs [32];
  longint      model_cnt;
  int          vectors;
  int          miscompares;

  function automatic logic [31:0] load_ref(input logic [2:0] lt, input logic [31:0] dout,
                                           input int off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(dout >> (8 * off));
    h = 16'(dout >> (16 * (off / 2)));
    case (lt)
      3'd1:    return 32'(int'($signed(b)));
      3'd2:    return 32'(int'(b));
      3'd3:    return 32'(int'($signed(h)));
      3'd4:    return 32'(int'(h));
      default: return dout;
    endcase
  endfunction

  task automatic apply(input logic rst, input logic valid, input logic regwr, input logic mtr,
                       input logic link, input logic [2:0] lt, input logic [4:0] rw,
                       input logic [31:0] dout, input logic [31:0] alu, input logic [29:0] pc,
                       input logic [4:0] ra, input logic [4:0] rb);
    exp_t        e;
    logic [31:0] wd;
    logic        en;
    Reset             = rst;
    bus.Wr_Valid      = valid;
    bus.Wr_RegWr      = regwr;
    bus.Wr_MemtoReg   = mtr;
    bus.Wr_Link       = link;
    bus.Wr_LdType     = lt;
    bus.Wr_Rw         = rw;
    bus.Wr_dout       = dout;
    bus.Wr_alu_result = alu;
    bus.Wr_PC         = pc;
    bus.Ra            = ra;
    bus.Rb            = rb;
    if (link)     wd = 32'((longint'(pc) + 1) % (64'd1 << 30)) * 32'd4;
    else if (mtr) wd = load_ref(lt, dout, int'(alu % 4));
    else          wd = alu;
    en     = valid && regwr && rw != 0 && !rst;
    e.wd   = wd;
    e.en   = en;
    e.a    = (ra == 0) ? 32'h0 : (en && ra == rw) ? wd : model_regs[ra];
    e.b    = (rb == 0) ? 32'h0 : (en && rb == rw) ? wd : model_regs[rb];
    e.cnt  = 32'(model_cnt % (64'd1 << 32));
    e.cnt4 = 4'(model_cnt % 16);
    exp_q.push_back(e);
    @(posedge Clk);
    if (rst) begin
      foreach (model_regs[i]) model_regs[i] = 32'h0;
      model_cnt = 0;
    end else begin
      if (en) model_regs[rw] = wd;
      if (valid) model_cnt = model_cnt + 1;
    end
    #1;
  endtask

  task automatic idle_read(input logic [4:0] ra, input logic [4:0] rb);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, ra, 32'h0, 32'hA5A5_A5A5, 30'h0, ra, rb);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (bus.busA !== e.a) begin
        miscompares++;
        $display("FAIL busA vec %0d: got %h expected %h", vectors, bus.busA, e.a);
      end
      if (bus.busB !== e.b) begin
        miscompares++;
        $display("FAIL busB vec %0d: got %h expected %h", vectors, bus.busB, e.b);
      end
      if (bus.Wr_Data !== e.wd) begin
        miscompares++;
        $display("FAIL Wr_Data vec %0d: got %h expected %h", vectors, bus.Wr_Data, e.wd);
      end
      if (bus.Wr_En !== e.en) begin
        miscompares++;
        $display("FAIL Wr_En vec %0d: got %b expected %b", vectors, bus.Wr_En, e.en);
      end
      if (bus.Ret_Cnt !== e.cnt) begin
        miscompares++;
        $display("FAIL Ret_Cnt vec %0d: got %h expected %h", vectors, bus.Ret_Cnt, e.cnt);
      end
      if (bus4.Ret_Cnt !== e.cnt4) begin
        miscompares++;
        $display("FAIL Ret_Cnt4 vec %0d: got %h expected %h", vectors, bus4.Ret_Cnt, e.cnt4);
      end
    end
  end

  initial begin
    logic [31:0] ld_dout;
    vectors     = 0;
    miscompares = 0;
    model_cnt   = 0;
    foreach (model_regs[i]) model_regs[i] = 32'h0;

    // First reset edge is unchecked: DUT state is unknown until it lands.
    Reset = 1'b1;
    bus.Wr_Valid = 1'b0; bus.Wr_RegWr = 1'b0; bus.Wr_MemtoReg = 1'b0; bus.Wr_Link = 1'b0;
    bus.Wr_LdType = 3'd0; bus.Wr_Rw = 5'd0; bus.Wr_dout = 32'h0; bus.Wr_alu_result = 32'h0;
    bus.Wr_PC = 30'h0; bus.Ra = 5'd0; bus.Rb = 5'd0;
    @(posedge Clk);
    #1;
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd9, 32'h0, 32'h1111_1111, 30'h0, 5'd9, 5'd9);

    for (int i = 0; i < 32; i++) idle_read(5'(i), 5'(i));

    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd5, 32'h0, 32'h1234_5678, 30'h0, 5'd5, 5'd0);
    idle_read(5'd5, 5'd5);

    ld_dout = 32'h80FF_7F01;
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 5'd7, ld_dout, 32'h0000_0103, 30'h0, 5'd7, 5'd7);
    idle_read(5'd7, 5'd0);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 5'd7, ld_dout, 32'h0000_0101, 30'h0, 5'd7, 5'd7);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 5'd7, ld_dout, 32'h0000_0102, 30'h0, 5'd7, 5'd7);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 5'd7, ld_dout, 32'h0000_0100, 30'h0, 5'd7, 5'd7);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 5'd7, ld_dout, 32'h0000_0102, 30'h0, 5'd7, 5'd7);
    idle_read(5'd7, 5'd7);

    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 5'd31, ld_dout, 32'h5, 30'h3FFF_FFFF, 5'd31, 5'd3);
    idle_read(5'd31, 5'd31);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 5'd31, 32'h0, 32'h5, 30'h100, 5'd31, 5'd31);
    idle_read(5'd31, 5'd30);

    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 32'hDEAD_BEEF, 30'h0, 5'd0, 5'd0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd6, 32'h0, 32'hCAFE_F00D, 30'h0, 5'd6, 5'd6);
    idle_read(5'd6, 5'd0);

    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd3, 32'h0, 32'h0BAD_0003, 30'h0, 5'd3, 5'd3);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd3, 32'h0, 32'h7777_7777, 30'h0, 5'd3, 5'd3);
    idle_read(5'd3, 5'd7);

    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd1, 32'h0, 32'h0, 30'h0, 5'd1, 5'd2);
    end

    for (int i = 0; i < 400; i++) begin
      logic [4:0] rw;
      logic [4:0] ra;
      logic [4:0] rb;
      rw = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
      apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 7) == 0),
            3'($urandom), rw, $urandom, $urandom, 30'($urandom), ra, rb);
    end

    for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge Clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
